// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master transmitter.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    ACK,
    HOLD,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam int I2C_BYTE_BITS      = 8;
  localparam int I2C_START_QUARTERS = 2;

  // SCL is low for the first half of a slot and high for the second half.
  function automatic logic scl_high(input quarter_t q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/i2c_master_tx_scl_quarter_tick.sv
// Divides clk into SCL quarter periods of CLK_DIV cycles; held at Q0/count 0 while en is low.
module scl_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output logic     tick,
  output quarter_t quarter
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  // NOTE: flops are written with <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (tick) begin
      cnt     <= '0;
      quarter <= quarter_t'(quarter + 2'd1);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Bit-level I2C master transmitter: START, MSB-first bytes with ACK slot, HOLD between bytes, STOP.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       byte_done,
  output logic       nack
);

  localparam logic [2:0] LAST_BIT     = 3'(I2C_BYTE_BITS - 1);
  localparam quarter_t   START_LAST_Q = quarter_t'(2'(I2C_START_QUARTERS - 1));

  state_t                   state, state_nxt;
  quarter_t                 quarter, quarter_nxt;
  logic [I2C_BYTE_BITS-1:0] shreg, shreg_nxt;
  logic [2:0]               bit_cnt, bit_cnt_nxt;
  logic                     last, last_nxt;
  logic [1:0]               sda_meta;
  logic                     sda_sync;
  logic                     tick, qt_en, slot_end, accept, sda_load;
  logic                     scl_nxt, sda_nxt, byte_done_nxt, nack_nxt;

  scl_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_quarter_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (qt_en),
    .tick   (tick),
    .quarter(quarter)
  );

  assign accept   = tx_valid && tx_ready;
  assign slot_end = tick && (quarter == Q3);
  assign sda_sync = sda_meta[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    last_nxt      = last;
    nack_nxt      = nack;
    byte_done_nxt = 1'b0;
    qt_en         = 1'b1;
    case (state)
      IDLE, HOLD: begin
        qt_en = 1'b0;
        if (accept) begin
          state_nxt   = (state == IDLE) ? START : BITS;
          shreg_nxt   = tx_data;
          last_nxt    = tx_last;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        // START is only half a slot long, so the quarter counter is cleared for bit 7.
        if (tick && (quarter == START_LAST_Q)) begin
          state_nxt = BITS;
          qt_en     = 1'b0;
        end
      end
      BITS: begin
        if (slot_end) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = ACK;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = {shreg[I2C_BYTE_BITS-2:0], 1'b0};
          end
        end
      end
      ACK: begin
        if (slot_end) begin
          nack_nxt      = sda_sync;
          byte_done_nxt = 1'b1;
          state_nxt     = last ? STOP : HOLD;
        end
      end
      STOP: begin
        if (slot_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Quarter seen after the coming edge; outputs are registered from it.
  always_comb begin
    quarter_nxt = quarter;
    if (!qt_en)    quarter_nxt = Q0;
    else if (tick) quarter_nxt = quarter_t'(quarter + 2'd1);
  end

  assign sda_load = (quarter_nxt == Q0) && (!qt_en || tick);

  always_comb begin
    scl_nxt = 1'b1;
    sda_nxt = sda_out;
    case (state_nxt)
      IDLE:  sda_nxt = 1'b1;
      START: sda_nxt = 1'b0;
      BITS: begin
        scl_nxt = scl_high(quarter_nxt);
        if (sda_load) sda_nxt = shreg_nxt[I2C_BYTE_BITS-1];
      end
      ACK: begin
        scl_nxt = scl_high(quarter_nxt);
        if (sda_load) sda_nxt = 1'b1;
      end
      HOLD: begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
      end
      STOP: begin
        scl_nxt = scl_high(quarter_nxt);
        sda_nxt = (quarter_nxt == Q3);
      end
      default: sda_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      last      <= 1'b0;
      sda_meta  <= 2'b11;
      scl_out   <= 1'b1;
      sda_out   <= 1'b1;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      nack      <= 1'b0;
    end else begin
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      last      <= last_nxt;
      sda_meta  <= {sda_meta[0], sda_in};
      scl_out   <= scl_nxt;
      sda_out   <= sda_nxt;
      tx_ready  <= (state_nxt == IDLE) || (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
      byte_done <= byte_done_nxt;
      nack      <= nack_nxt;
    end
  end

endmodule
